// File: rtl/seq_shift_pkg.sv
// seq_shift_pkg: shared encodings for the sequential shifter
package seq_shift_pkg;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic MODE_SHIFT = 1'b0;
  localparam logic MODE_ROT = 1'b1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/seq_shift8_step.sv
// shift_step: single-position logical shift or rotate
module shift_step import seq_shift_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] w,
  input  logic             d,
  input  logic             rot,
  output logic [WIDTH-1:0] w_next
);
  logic fill_r, fill_l;
  assign fill_r = (rot == MODE_ROT) & w[0];
  assign fill_l = (rot == MODE_ROT) & w[WIDTH-1];
  assign w_next = (d == DIR_RIGHT) ? {fill_r, w[WIDTH-1:1]} : {w[WIDTH-2:0], fill_l};
endmodule

// File: rtl/seq_shift8.sv
// seq_shift8: handshaked shifter/rotator moving one bit position per clock
module seq_shift8 import seq_shift_pkg::*; #(
  parameter int WIDTH = 8,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    s,
  input  logic             d,
  input  logic             rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);
  state_t state, state_n;
  logic [WIDTH-1:0] w, w_next;
  logic [SW-1:0] cnt;
  logic dir, mode;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out = w;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .w(w),
    .d(dir),
    .rot(mode),
    .w_next(w_next)
  );
  // next state; unused encodings fall back to IDLE
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE) ? (in_valid ? SHIFT : IDLE) :
              (state == SHIFT) ? ((cnt == '0) ? DONE : SHIFT) :
              (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // state, work register and step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      w <= '0;
      cnt <= '0;
      dir <= DIR_LEFT;
      mode <= MODE_SHIFT;
    end else begin
      state <= state_n;
      if (in_valid && in_ready) begin
        w <= a;
        cnt <= s;
        dir <= d;
        mode <= rot;
      end else if (state == SHIFT && cnt != '0) begin
        w <= w_next;
        cnt <= cnt - SW'(1);
      end
    end
  end
endmodule
